// File: rtl/BasicTypes.sv
// Core-wide basic types shared across the front end.
package BasicTypes;

  localparam int ADDR_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] PC;

endpackage

// File: rtl/FetchUnitTypes.sv
// Fetch-unit types: queue sizing and the entry handed from fetch to decode.
package FetchUnitTypes;
  import BasicTypes::*;

  localparam int FETCH_QUEUE_DEPTH = 4;

  typedef struct packed {
    PC           pc;
    logic [31:0] insn;
    logic        predTaken;
    PC           predNpc;
  } FetchQueueEntry;

endpackage

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode; full stalls next-PC generation,
// flush discards everything on a redirect.
module fetch_queue
  import BasicTypes::*;
  import FetchUnitTypes::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     flush,
  input  logic                     enqValid,
  input  PC                        enqPc,
  input  logic [31:0]              enqInsn,
  input  logic                     enqPredTaken,
  input  PC                        enqPredNpc,
  output logic                     full,
  input  logic                     deqReady,
  output logic                     deqValid,
  output PC                        deqPc,
  output logic [31:0]              deqInsn,
  output logic                     deqPredTaken,
  output PC                        deqPredNpc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] Ptr;
  typedef logic [PTR_W:0]   Cnt;

  localparam Cnt FULL_COUNT = Cnt'(DEPTH);
  localparam Cnt ZERO_COUNT = Cnt'(1'b0);

  FetchQueueEntry entries_r [DEPTH];
  Ptr             head_r;
  Ptr             tail_r;
  Cnt             count_r;

  logic           doEnq_s;
  logic           doDeq_s;
  FetchQueueEntry enqEntry_s;
  FetchQueueEntry headEntry_s;

  // Status flags and handshake qualification, derived from registered count only.
  always_comb begin
    full       = (count_r == FULL_COUNT);
    deqValid   = (count_r != ZERO_COUNT);
    doEnq_s    = enqValid && !full && !flush;
    doDeq_s    = deqValid && deqReady && !flush;
    enqEntry_s = '{pc: enqPc, insn: enqInsn, predTaken: enqPredTaken, predNpc: enqPredNpc};
  end

  // Head entry presented to decode; forced to zero while the queue is empty.
  always_comb begin
    headEntry_s = {$bits(FetchQueueEntry){1'b0}};
    if (deqValid) begin
      headEntry_s = entries_r[head_r];
    end else begin
      headEntry_s = {$bits(FetchQueueEntry){1'b0}};
    end
    deqPc        = headEntry_s.pc;
    deqInsn      = headEntry_s.insn;
    deqPredTaken = headEntry_s.predTaken;
    deqPredNpc   = headEntry_s.predNpc;
    count        = count_r;
  end

  // Entry storage; contents survive reset and are only meaningful below count.
  always_ff @(posedge clk) begin
    if (doEnq_s) begin
      entries_r[tail_r] <= enqEntry_s;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head_r  <= Ptr'(1'b0);
      tail_r  <= Ptr'(1'b0);
      count_r <= ZERO_COUNT;
    end else if (flush) begin
      head_r  <= Ptr'(1'b0);
      tail_r  <= Ptr'(1'b0);
      count_r <= ZERO_COUNT;
    end else begin
      if (doEnq_s) begin
        tail_r <= tail_r + Ptr'(1'b1);
      end
      if (doDeq_s) begin
        head_r <= head_r + Ptr'(1'b1);
      end
      case ({doEnq_s, doDeq_s})
        2'b10:   count_r <= count_r + Cnt'(1'b1);
        2'b01:   count_r <= count_r - Cnt'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_fetch_queue;
  import BasicTypes::*;
  import FetchUnitTypes::*;

  localparam int DEPTH = FETCH_QUEUE_DEPTH;

  typedef struct {
    PC           pc;
    logic [31:0] insn;
    logic        pt;
    PC           npc;
  } ent_t;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        enqValid;
  PC           enqPc;
  logic [31:0] enqInsn;
  logic        enqPredTaken;
  PC           enqPredNpc;
  logic        full;
  logic        deqReady;
  logic        deqValid;
  PC           deqPc;
  logic [31:0] deqInsn;
  logic        deqPredTaken;
  PC           deqPredNpc;
  logic [2:0]  count;

  ent_t mq[$];
  int   tests = 0;
  int   fails = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .enqValid(enqValid), .enqPc(enqPc), .enqInsn(enqInsn),
    .enqPredTaken(enqPredTaken), .enqPredNpc(enqPredNpc),
    .full(full), .deqReady(deqReady), .deqValid(deqValid),
    .deqPc(deqPc), .deqInsn(deqInsn), .deqPredTaken(deqPredTaken),
    .deqPredNpc(deqPredNpc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: model decides acceptance from pre-edge state, then tracks the edge.
  task automatic cycle();
    bit e;
    bit d;
    e = enqValid && !flush && (mq.size() < DEPTH);
    d = deqReady && !flush && (mq.size() != 0);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (d) void'(mq.pop_front());
      if (e) mq.push_back('{enqPc, enqInsn, enqPredTaken, enqPredNpc});
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; enqValid = 1'b0; deqReady = 1'b0;
    enqPc = 32'h0; enqInsn = 32'h0; enqPredTaken = 1'b0; enqPredNpc = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstN = 1'b0;
    mq.delete();
    #2;
    rstN = 1'b1;
    cycle();
  endtask

  task automatic enq(input PC pc, input logic [31:0] insn, input logic pt, input PC npc);
    enqValid = 1'b1; enqPc = pc; enqInsn = insn; enqPredTaken = pt; enqPredNpc = npc;
    cycle();
    enqValid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstN = 1'b0;
    #1;
    tests++;
    if (deqValid !== 1'b0 || full !== 1'b0 || count !== 3'd0 || deqPc !== 32'h0 ||
        deqInsn !== 32'h0 || deqPredTaken !== 1'b0 || deqPredNpc !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b full=%b count=%0d pc=%h insn=%h pt=%b npc=%h, expected all zero",
               deqValid, full, count, deqPc, deqInsn, deqPredTaken, deqPredNpc);
    end
    #1;
    rstN = 1'b1;
    mq.delete();
    cycle();
  endtask

  task automatic test_single();
    apply_reset();
    enqValid = 1'b1; enqPc = 32'h100; enqInsn = 32'h00000013;
    #1;
    tests++;
    if (deqValid !== 1'b0) begin
      fails++; $display("FAIL single_no_bypass: deqValid=%b expected 0", deqValid);
    end
    cycle();
    enqValid = 1'b0;
    tests++;
    if (deqValid !== 1'b1 || deqPc !== 32'h100 || deqInsn !== 32'h00000013 || count !== 3'd1) begin
      fails++;
      $display("FAIL single_enq: valid=%b pc=%h insn=%h count=%0d expected 1 00000100 00000013 1",
               deqValid, deqPc, deqInsn, count);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 4; i++) enq(32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 32'h0);
    tests++;
    if (full !== 1'b1 || count !== 3'd4) begin
      fails++; $display("FAIL full_flag: full=%b count=%0d expected 1 4", full, count);
    end
    enq(32'h110, 32'hBAD, 1'b0, 32'h0);
    tests++;
    if (count !== 3'd4 || deqPc !== 32'h100) begin
      fails++; $display("FAIL full_drop: count=%0d head=%h expected 4 00000100", count, deqPc);
    end
    deqReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (deqValid !== 1'b1 || deqPc !== 32'h100 + 32'(4 * i)) begin
        fails++;
        $display("FAIL full_drain[%0d]: valid=%b pc=%h expected 1 %h", i, deqValid, deqPc, 32'h100 + 32'(4 * i));
      end
      cycle();
    end
    deqReady = 1'b0;
    tests++;
    if (deqValid !== 1'b0 || count !== 3'd0) begin
      fails++; $display("FAIL full_empty: valid=%b count=%0d expected 0 0", deqValid, count);
    end
  endtask

  task automatic test_full_deq();
    apply_reset();
    for (int i = 0; i < 4; i++) enq(32'h100 + 32'(4 * i), 32'h13, 1'b0, 32'h0);
    enqValid = 1'b1; enqPc = 32'h200; deqReady = 1'b1;
    cycle();
    enqValid = 1'b0;
    tests++;
    if (count !== 3'd3 || deqPc !== 32'h104 || full !== 1'b0) begin
      fails++; $display("FAIL full_deq: count=%0d head=%h full=%b expected 3 00000104 0", count, deqPc, full);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (deqPc !== 32'h104 + 32'(4 * i)) begin
        fails++; $display("FAIL full_deq_order[%0d]: pc=%h expected %h", i, deqPc, 32'h104 + 32'(4 * i));
      end
      cycle();
    end
    deqReady = 1'b0;
    tests++;
    if (deqValid !== 1'b0) begin
      fails++; $display("FAIL full_deq_nowrite: deqValid=%b pc=%h expected empty", deqValid, deqPc);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    enq(32'h100, 32'h1, 1'b0, 32'h0);
    enq(32'h104, 32'h2, 1'b0, 32'h0);
    flush = 1'b1; enqValid = 1'b1; enqPc = 32'h300; deqReady = 1'b1;
    cycle();
    idle_inputs();
    tests++;
    if (count !== 3'd0 || deqValid !== 1'b0 || full !== 1'b0 || deqPc !== 32'h0) begin
      fails++;
      $display("FAIL flush: count=%0d valid=%b full=%b pc=%h expected 0 0 0 00000000", count, deqValid, full, deqPc);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    enq(32'h300, 32'h13, 1'b1, 32'h200);
    enqValid = 1'b1; deqReady = 1'b1; enqPredTaken = 1'b1; enqPredNpc = 32'h200;
    for (int i = 0; i < 10; i++) begin
      enqPc = 32'h304 + 32'(4 * i);
      enqInsn = 32'h50 + 32'(i);
      tests++;
      if (deqPc !== 32'h300 + 32'(4 * i) || deqPredTaken !== 1'b1 || deqPredNpc !== 32'h200) begin
        fails++;
        $display("FAIL b2b_head[%0d]: pc=%h pt=%b npc=%h expected %h 1 00000200",
                 i, deqPc, deqPredTaken, deqPredNpc, 32'h300 + 32'(4 * i));
      end
      cycle();
      tests++;
      if (count !== 3'd1) begin
        fails++; $display("FAIL b2b_count[%0d]: count=%0d expected 1", i, count);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) enq(32'h400 + 32'(4 * i), 32'h13, 1'b0, 32'h0);
    #1;
    rstN = 1'b0;
    mq.delete();
    #1;
    tests++;
    if (deqValid !== 1'b0 || count !== 3'd0 || full !== 1'b0 || deqPc !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: valid=%b count=%0d full=%b pc=%h expected 0 0 0 00000000", deqValid, count, full, deqPc);
    end
    #1;
    rstN = 1'b1;
    #1;
    enq(32'h500, 32'h13, 1'b0, 32'h0);
    tests++;
    if (count !== 3'd1 || deqPc !== 32'h500) begin
      fails++; $display("FAIL reset_resume: count=%0d pc=%h expected 1 00000500", count, deqPc);
    end
  endtask

  task automatic test_random();
    ent_t exp_e;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      enqValid     = ($urandom_range(0, 3) != 0);
      deqReady     = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 29) == 0);
      enqPc        = $urandom();
      enqInsn      = $urandom();
      enqPredTaken = 1'($urandom_range(0, 1));
      enqPredNpc   = $urandom();
      #1;
      exp_e = '{32'h0, 32'h0, 1'b0, 32'h0};
      if (mq.size() != 0) exp_e = mq[0];
      tests++;
      if (deqValid !== (mq.size() != 0) || full !== (mq.size() == DEPTH) || count !== 3'(mq.size()) ||
          deqPc !== exp_e.pc || deqInsn !== exp_e.insn || deqPredTaken !== exp_e.pt || deqPredNpc !== exp_e.npc) begin
        fails++;
        $display("FAIL random[%0d]: valid=%b full=%b count=%0d pc=%h insn=%h pt=%b npc=%h expected count=%0d pc=%h insn=%h pt=%b npc=%h",
                 c, deqValid, full, count, deqPc, deqInsn, deqPredTaken, deqPredNpc,
                 mq.size(), exp_e.pc, exp_e.insn, exp_e.pt, exp_e.npc);
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_full_deq();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
